// File: rtl/tdm_demux_4ch.sv
// Receive side of a 4-slot TDM link: tracks frame alignment from the slot-0
// marker and presents each completed frame on O0..O3 with a one-cycle strobe.

module tdm_demux_lane #(
  parameter int W      = 8,
  parameter bit DIRECT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         we,
  input  logic         commit,
  output logic [W-1:0] o
);

  generate
    if (DIRECT) begin : g_direct
      // The last slot lands in the output straight from the wire on commit.
      logic unused_we;
      assign unused_we = we;

      always_ff @(posedge clk) begin
        if (rst)         o <= '0;
        else if (commit) o <= din;
      end
    end else begin : g_staged
      logic [W-1:0] s;

      always_ff @(posedge clk) begin
        if (rst) begin
          s <= '0;
          o <= '0;
        end else begin
          if (we)     s <= din;
          if (commit) o <= s;
        end
      end
    end
  endgenerate

endmodule

module tdm_demux_4ch #(
  parameter int W      = 8,
  parameter int STRICT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] O0,
  output logic [W-1:0] O1,
  output logic [W-1:0] O2,
  output logic [W-1:0] O3,
  output logic         frame_valid,
  output logic [1:0]   sel,
  output logic         locked,
  output logic         sync_err
);

  localparam int NUM_LANES = 4;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                            state_q, state_d;
  logic [1:0]                        sel_q, sel_d;
  logic                              fv_q, err_q, err_d, commit;
  logic [NUM_LANES-1:0]              stage_we;
  logic [NUM_LANES-1:0][W-1:0]       o_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sel_q   <= 2'd0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      fv_q    <= commit;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    stage_we = '0;
    commit   = 1'b0;
    err_d    = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            stage_we[0] = 1'b1;
            sel_d       = 2'd1;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A marker mid-frame means we slipped: restart the frame here.
            stage_we[0] = 1'b1;
            sel_d       = 2'd1;
            err_d       = (sel_q != 2'd0);
          end else if (sel_q == 2'd0) begin
            if (STRICT != 0) begin
              err_d   = 1'b1;
              sel_d   = 2'd0;
              state_d = HUNT;
            end else begin
              stage_we[0] = 1'b1;
              sel_d       = 2'd1;
            end
          end else if (sel_q == 2'd3) begin
            commit = 1'b1;
            sel_d  = 2'd0;
          end else begin
            stage_we[sel_q] = 1'b1;
            sel_d           = sel_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      tdm_demux_lane #(
        .W      (W),
        .DIRECT (i == NUM_LANES-1)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .we     (stage_we[i]),
        .commit (commit),
        .o      (o_q[i])
      );
    end
  endgenerate

  assign O0          = o_q[0];
  assign O1          = o_q[1];
  assign O2          = o_q[2];
  assign O3          = o_q[3];
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign sel         = sel_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: a relaxed and a strict instance share one stimulus
// stream and are checked every cycle against a frame-assembly model.

module tb_tdm_demux_4ch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] din = '0;
  logic din_valid = 1'b0;
  logic frame_sync = 1'b0;

  logic [1:0][3:0][7:0] dout;
  logic [1:0]           fv, lk, er;
  logic [1:0][1:0]      sel;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int fv_cnt = 0;

  always #5 clk = ~clk;

  tdm_demux_4ch #(.W(8), .STRICT(0)) u0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .O0(dout[0][0]), .O1(dout[0][1]), .O2(dout[0][2]), .O3(dout[0][3]),
    .frame_valid(fv[0]), .sel(sel[0]), .locked(lk[0]), .sync_err(er[0]));

  tdm_demux_4ch #(.W(8), .STRICT(1)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .O0(dout[1][0]), .O1(dout[1][1]), .O2(dout[1][2]), .O3(dout[1][3]),
    .frame_valid(fv[1]), .sel(sel[1]), .locked(lk[1]), .sync_err(er[1]));

  // Model: a frame is a list of collected samples; m_n is how many so far.
  logic [1:0][3:0][7:0] m_o   = '0;
  logic [1:0][3:0][7:0] m_buf = '0;
  int                   m_n[2]  = '{0, 0};
  bit                   m_lk[2] = '{0, 0};
  bit                   m_fv[2] = '{0, 0};
  bit                   m_err[2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_fv[k]  = 1'b0;
      m_err[k] = 1'b0;
      if (rst) begin
        m_lk[k] = 1'b0;
        m_n[k]  = 0;
        m_o[k]  = '0;
      end else if (din_valid) begin
        if (!m_lk[k]) begin
          if (frame_sync) begin
            m_buf[k][0] = din;
            m_n[k]      = 1;
            m_lk[k]     = 1'b1;
          end
        end else if (frame_sync) begin
          m_err[k]    = (m_n[k] != 0);
          m_buf[k][0] = din;
          m_n[k]      = 1;
        end else if (m_n[k] == 0 && k == 1) begin
          m_err[k] = 1'b1;
          m_lk[k]  = 1'b0;
        end else begin
          m_buf[k][m_n[k]] = din;
          m_n[k]++;
          if (m_n[k] == 4) begin
            m_o[k]  = m_buf[k];
            m_fv[k] = 1'b1;
            m_n[k]  = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit s, input logic [7:0] d);
    rst = r; din_valid = v; frame_sync = s; din = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("O%0d", k), dout[k], m_o[k]);
        chk($sformatf("frame_valid%0d", k), {31'd0, fv[k]}, {31'd0, m_fv[k]});
        chk($sformatf("sync_err%0d", k), {31'd0, er[k]}, {31'd0, m_err[k]});
        chk($sformatf("sel%0d", k), {30'd0, sel[k]}, m_n[k] & 3);
        chk($sformatf("locked%0d", k), {31'd0, lk[k]}, {31'd0, m_lk[k]});
      end
      if (fv[0]) fv_cnt++;
    end
  end

  initial begin
    int base;
    bit v, s, r;
    // Reset
    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    chk_en = 1'b1;
    cyc(0, 0, 0, 8'h00);
    chk("rst_O", dout[0], 32'h0);
    chk("rst_state", {lk[0], sel[0], fv[0], er[0]}, 32'h0);

    // HUNT drops unsynced samples, then locks
    cyc(0, 1, 0, 8'h11);
    cyc(0, 1, 0, 8'h22);
    chk("hunt_sel", {30'd0, sel[0]}, 32'd0);
    base = fv_cnt;
    cyc(0, 1, 1, 8'hA0);
    cyc(0, 1, 0, 8'hA1);
    cyc(0, 1, 0, 8'hA2);
    cyc(0, 1, 0, 8'hA3);
    chk("lock_O", dout[0], 32'hA3A2A1A0);
    chk("lock_fv_lk", {30'd0, fv[0], lk[0]}, 32'd3);
    cyc(0, 0, 0, 8'h00);
    #1 chk("lock_pulses", fv_cnt - base, 32'd1);

    // Gapped then back-to-back frames
    base = fv_cnt;
    cyc(0, 1, 1, 8'h10); cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h11); cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h12); cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h13);
    chk("gap_O", dout[0], 32'h13121110);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, (i % 4) == 0, 8'h20 + 8'(i));
      if (i < 4) chk("b2b_sel", {30'd0, sel[0]}, (i + 1) % 4);
      if (i == 3) chk("b2b_O1", dout[0], 32'h23222120);
    end
    chk("b2b_O2", dout[0], 32'h27262524);
    cyc(0, 0, 0, 8'h00);
    #1 chk("b2b_pulses", fv_cnt - base, 32'd3);

    // Early resync
    cyc(0, 1, 1, 8'h30);
    cyc(0, 1, 0, 8'h31);
    cyc(0, 1, 1, 8'h40);
    chk("resync_err", {31'd0, er[0]}, 32'd1);
    chk("resync_hold", dout[0], 32'h27262524);
    cyc(0, 1, 0, 8'h41);
    cyc(0, 1, 0, 8'h42);
    cyc(0, 1, 0, 8'h43);
    chk("resync_O", dout[0], 32'h43424140);

    // Missing sync on slot 0: strict instance drops lock
    cyc(0, 1, 0, 8'h55);
    chk("strict_err", {29'd0, er[1], lk[1], sel[1]}, 32'h8);
    chk("strict_hold", dout[1], 32'h43424140);
    cyc(0, 1, 1, 8'h56);
    cyc(0, 1, 0, 8'h57);
    cyc(0, 1, 0, 8'h58);
    cyc(0, 1, 0, 8'h59);
    chk("strict_relock", dout[1], 32'h59585756);

    // Reset mid-frame
    cyc(0, 1, 1, 8'h60);
    cyc(0, 1, 0, 8'h61);
    cyc(1, 1, 0, 8'h62);
    chk("midrst", {dout[0], 1'b0, lk[0], sel[0]}, 32'h0);
    cyc(0, 1, 1, 8'h70);
    cyc(0, 1, 0, 8'h71);
    cyc(0, 1, 0, 8'h72);
    cyc(0, 1, 0, 8'h73);
    chk("midrst_O", dout[0], 32'h73727170);

    // Randomized traffic, biased toward well-formed frames
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom % 200) == 0;
      v = ($urandom % 4) != 0;
      if (m_n[1] == 0) s = ($urandom % 8) != 0;
      else             s = ($urandom % 16) == 0;
      cyc(r, v, s, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
- Receive end of the 4-to-1 channel multiplexer: takes one time-division-multiplexed sample stream and demultiplexes it into four parallel channel registers O0..O3.
- An internal 2-bit slot counter plays the role of the mux select (s1,s0); slot 0 ↔ I0 … slot 3 ↔ I3.
- Frames are aligned by a frame_sync marker on the slot-0 sample.
- Completed frames are presented atomically with a one-cycle frame_valid strobe.

Parameters:
W, 8, width of each sample and each channel output
STRICT, 0, 1 = frame_sync required on every slot-0 sample; 0 = frame_sync optional once locked

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
din  input  W  TDM sample
din_valid  input  1  din carries a sample this cycle
frame_sync  input  1  qualifies the current din as slot 0; ignored when din_valid=0
O0  output  W  channel 0 (slot 0) of last complete frame
O1  output  W  channel 1 (slot 1)
O2  output  W  channel 2 (slot 2)
O3  output  W  channel 3 (slot 3)
frame_valid  output  1  one-cycle pulse: O0..O3 just updated with a new frame
sel  output  2  {s1,s0}: slot the next accepted sample will fill
locked  output  1  1 in LOCKED state
sync_err  output  1  one-cycle pulse on alignment error

Behaviour:
- Reset (rst=1 at posedge, checked before all else): O0..O3=0, frame_valid=0, sync_err=0, sel=0, locked=0, state=HUNT. Staging registers S0..S2 are cleared and any partial frame is discarded, including mid-frame.
- A sample is accepted only when din_valid=1. Cycles with din_valid=0 change nothing; frame_valid and sync_err fall back to 0.
- HUNT state:
  - din_valid & frame_sync: store din in S0, sel←1, state←LOCKED, locked←1.
  - din_valid & !frame_sync: sample dropped, sel stays 0, no error.
- LOCKED state, per accepted sample:
  - sel=0, frame_sync=1: store S0, sel←1.
  - sel=0, frame_sync=0, STRICT=0: store S0, sel←1.
  - sel=0, frame_sync=0, STRICT=1: sample dropped, sync_err pulse, state←HUNT, locked←0, sel←0.
  - sel=1 or 2, frame_sync=0: store S[sel], sel←sel+1.
  - sel=3, frame_sync=0: in one edge O0←S0, O1←S1, O2←S2, O3←din; frame_valid←1 for exactly one cycle; sel wraps 3→0.
  - sel≠0, frame_sync=1 (early resync): partial frame discarded, O* unchanged, sync_err pulse, din stored in S0, sel←1, stays LOCKED.
- Latency: frame_valid and new O* are visible the cycle after the slot-3 sample is sampled.
  - Back-to-back frames at full rate give frame_valid every 4th cycle.
  - A slot-0 sample in the cycle right after slot 3 is accepted normally.
- O0..O3 hold their value between frames; only a full frame or rst changes them.
- frame_valid and sync_err are never asserted in the same cycle.

Test Plan:
- Reset check: rst=1 for 2 cycles then 0 → O0..O3=0, sel=0, locked=0, frame_valid=0, sync_err=0.
- HUNT ignore then lock: din 0x11,0x22 without sync, then 0xA0(sync),0xA1,0xA2,0xA3 → first two dropped; 1 cycle after 0xA3: O0..O3=A0,A1,A2,A3, frame_valid single pulse, locked=1.
- Gapped valid and back-to-back frames: din_valid toggled 1/0 across frame 0x10..0x13, then 8 consecutive samples 0x20..0x27 → frames {10,11,12,13}, {20..23}, {24..27}; frame_valid exactly 3 single pulses; sel sequence 0,1,2,3,0.
- Early resync: after locking, 0x30,0x31, then 0x40 with sync, 0x41,0x42,0x43 → sync_err one pulse on 0x40; O stays on previous frame until 0x40..0x43 lands.
- STRICT=1 missing sync: locked, complete frame, then slot-0 sample 0x55 without sync → sync_err pulse, locked=0, sel=0, O unchanged; relock on next sync.
- Reset mid-frame: accept 0x60,0x61 then rst=1 → all outputs 0, HUNT; subsequent 0x70(sync)..0x73 yields O=70,71,72,73 with no residue from 0x60/0x61.
